am_insert_timer: RTL and testbench

//  TX-side slot scheduler for alignment-marker (AM) insertion in the 100GbE PCS.

---
 rtl/am_insert_timer.sv | 101 ++++++++++
 tb/tb_am_insert_timer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/am_insert_timer.sv
// Alignment-marker slot scheduler: counts data-block slots and, at the end of each
// period, claims N_LANES consecutive slots for AM blocks (lane 0 first).
module am_insert_timer #(
   parameter  int N_LANES    = 20,
   parameter  int MAX_WINDOW = 327660,
   localparam int NB_CNT     = $clog2(MAX_WINDOW + 1),
   localparam int NB_LANE    = $clog2(N_LANES)
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic               i_valid,
   input  logic [NB_CNT-1:0]  i_period_limit,
   output logic               o_data_ready,
   output logic               o_am_insert,
   output logic [NB_LANE-1:0] o_am_lane,
   output logic               o_am_start,
   output logic               o_period_done
);

   typedef enum logic {
      ST_DATA   = 1'b0,
      ST_INSERT = 1'b1
   } state_e;

   localparam logic [NB_CNT-1:0]  MAX_LIMIT = NB_CNT'(MAX_WINDOW);
   localparam logic [NB_LANE-1:0] LAST_LANE = NB_LANE'(N_LANES - 1);

   state_e              state_q,    state_d;
   logic [NB_CNT-1:0]   data_cnt_q, data_cnt_d;
   logic [NB_LANE-1:0]  lane_cnt_q, lane_cnt_d;

   logic [NB_CNT-1:0]   lim_clamped;
   logic [NB_CNT-1:0]   last_idx;
   logic                period_end;

   // The live limit is used every slot, so a shrinking limit ends the period at once
   // instead of letting data_cnt wrap; 0 behaves as 1 and oversize values clamp.
   always_comb begin
      lim_clamped = (i_period_limit > MAX_LIMIT) ? MAX_LIMIT : i_period_limit;
      last_idx    = (lim_clamped == '0) ? '0 : lim_clamped - NB_CNT'(1);
      period_end  = (data_cnt_q >= last_idx);
   end

   // NOTE: every next-state variable gets a default first so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      data_cnt_d = data_cnt_q;
      lane_cnt_d = lane_cnt_q;
      if (!i_enable) begin
         state_d    = ST_INSERT;
         data_cnt_d = '0;
         lane_cnt_d = '0;
      end else if (i_valid) begin
         unique case (state_q)
            ST_DATA: begin
               if (period_end) begin
                  state_d    = ST_INSERT;
                  data_cnt_d = '0;
               end else begin
                  data_cnt_d = data_cnt_q + NB_CNT'(1);
               end
            end
            ST_INSERT: begin
               if (lane_cnt_q == LAST_LANE) begin
                  state_d    = ST_DATA;
                  lane_cnt_d = '0;
               end else begin
                  lane_cnt_d = lane_cnt_q + NB_LANE'(1);
               end
            end
            default: state_d = ST_INSERT;
         endcase
      end
   end

   // NOTE: state uses non-blocking assignments; reset is synchronous so the
   // reset state appears on the cycle after i_reset regardless of i_valid.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q    <= ST_INSERT;
         data_cnt_q <= '0;
         lane_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         data_cnt_q <= data_cnt_d;
         lane_cnt_q <= lane_cnt_d;
      end
   end

   // Outputs are decoded from the registered state within the slot; i_enable gates
   // them directly so disabling aborts a burst in the same cycle.
   always_comb begin
      o_am_insert   = i_enable && (state_q == ST_INSERT);
      o_data_ready  = !o_am_insert;
      o_am_lane     = o_am_insert ? lane_cnt_q : '0;
      o_am_start    = o_am_insert && (lane_cnt_q == '0);
      o_period_done = i_enable && (state_q == ST_DATA) && period_end;
   end

endmodule

// File: tb/tb_am_insert_timer.sv
// Scoreboard bench for am_insert_timer (N_LANES=4, MAX_WINDOW=40): stimulus pushes the
// expected slot outputs, a negedge monitor pops and compares them.
module tb_am_insert_timer;

   localparam int N_LANES    = 4;
   localparam int MAX_WINDOW = 40;
   localparam int NB_CNT     = $clog2(MAX_WINDOW + 1);
   localparam int NB_LANE    = $clog2(N_LANES);

   typedef struct packed {
      logic               ready;
      logic               ins;
      logic [NB_LANE-1:0] lane;
      logic               start;
      logic               done;
   } slot_t;

   logic               i_clock = 1'b0;
   logic               i_reset = 1'b1;
   logic               i_enable = 1'b1;
   logic               i_valid = 1'b0;
   logic [NB_CNT-1:0]  i_period_limit = NB_CNT'(8);
   logic               o_data_ready;
   logic               o_am_insert;
   logic [NB_LANE-1:0] o_am_lane;
   logic               o_am_start;
   logic               o_period_done;

   am_insert_timer #(.N_LANES(N_LANES), .MAX_WINDOW(MAX_WINDOW)) dut (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .i_enable       (i_enable),
      .i_valid        (i_valid),
      .i_period_limit (i_period_limit),
      .o_data_ready   (o_data_ready),
      .o_am_insert    (o_am_insert),
      .o_am_lane      (o_am_lane),
      .o_am_start     (o_am_start),
      .o_period_done  (o_period_done)
   );

   always #5 i_clock = ~i_clock;

   int    n_checks = 0;
   int    n_pass   = 0;
   slot_t sb_q[$];
   string tag_q[$];
   string cur_tag  = "init";

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
   endtask

   // Reference: where we are in the period, in plain integers.
   bit m_init = 0;
   bit m_in_burst;
   int m_lane, m_cnt;

   function automatic int eff_limit(input int lim);
      if (lim == 0) return 1;
      if (lim > MAX_WINDOW) return MAX_WINDOW;
      return lim;
   endfunction

   // One slot: drive inputs, push what the outputs must be now, advance the model.
   task automatic step(input bit rst, input bit en, input bit vld, input int lim);
      slot_t e;
      int    eff;
      @(posedge i_clock);
      #1;
      i_reset        = rst;
      i_enable       = en;
      i_valid        = vld;
      i_period_limit = NB_CNT'(lim);
      eff = eff_limit(lim);
      if (m_init) begin
         e = '0;
         if (!en) begin
            e.ready = 1'b1;
         end else if (m_in_burst) begin
            e.ins   = 1'b1;
            e.lane  = NB_LANE'(m_lane);
            e.start = (m_lane == 0);
         end else begin
            e.ready = 1'b1;
            e.done  = (m_cnt + 1 >= eff);
         end
         sb_q.push_back(e);
         tag_q.push_back(cur_tag);
      end
      if (rst) begin
         m_init = 1; m_in_burst = 1; m_lane = 0; m_cnt = 0;
      end else if (!en) begin
         m_in_burst = 1; m_lane = 0; m_cnt = 0;
      end else if (vld) begin
         if (m_in_burst) begin
            if (m_lane == N_LANES - 1) begin m_in_burst = 0; m_lane = 0; end
            else m_lane++;
         end else begin
            if (m_cnt + 1 >= eff) begin m_in_burst = 1; m_cnt = 0; end
            else m_cnt++;
         end
      end
   endtask

   always @(negedge i_clock) begin
      slot_t a, e;
      string t;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         t = tag_q.pop_front();
         a = '{o_data_ready, o_am_insert, o_am_lane, o_am_start, o_period_done};
         check({t, " slot"}, 32'(a), 32'(e));
         check({t, " ready/insert exclusive"}, 32'(o_data_ready & o_am_insert), 32'd0);
      end
   end

   initial begin
      // 1: continuous valid, limit 8: 4 AM slots then 8 data slots, repeating.
      cur_tag = "t1_continuous";
      step(1, 1, 1, 8);
      repeat (36) step(0, 1, 1, 8);

      // 2: valid every other cycle stretches burst to 8 cycles and period to 16.
      cur_tag = "t2_toggle";
      step(1, 1, 1, 8);
      for (int i = 0; i < 56; i++) step(0, 1, (i % 2) == 0, 8);

      // 3: limit 8->3 when data_cnt=5 ends the period at once; then limit 0.
      cur_tag = "t3_limit_shrink";
      step(1, 1, 1, 8);
      repeat (9) step(0, 1, 1, 8);
      step(0, 1, 0, 3);
      repeat (7) step(0, 1, 1, 3);
      cur_tag = "t3_limit_zero";
      repeat (15) step(0, 1, 1, 0);
      cur_tag = "t3_limit_clamp";
      repeat (50) step(0, 1, 1, 63);
      cur_tag = "t3_limit_max";
      repeat (50) step(0, 1, 1, MAX_WINDOW);

      // 4: disable at lane 2 aborts the burst; re-enable restarts at lane 0.
      cur_tag = "t4_enable";
      step(1, 1, 1, 8);
      repeat (2) step(0, 1, 1, 8);
      repeat (3) step(0, 0, 1, 8);
      step(0, 0, 0, 8);
      repeat (14) step(0, 1, 1, 8);
      repeat (3) step(0, 0, 1, 8);
      repeat (6) step(0, 1, 1, 8);

      // 5: reset at data_cnt=6, with valid low, returns to AM lane 0.
      cur_tag = "t5_reset_mid";
      step(1, 1, 1, 8);
      repeat (10) step(0, 1, 1, 8);
      step(1, 1, 0, 8);
      repeat (6) step(0, 1, 1, 8);
      step(1, 1, 1, 8);
      repeat (3) step(0, 1, 0, 8);

      // 6: random valid / enable / limit / rare reset.
      cur_tag = "t6_random";
      for (int i = 0; i < 3000; i++) begin
         int lim;
         lim = ($urandom_range(0, 9) == 0) ? 63 : int'($urandom_range(0, 10));
         step($urandom_range(0, 199) == 0, $urandom_range(0, 19) != 0,
              $urandom_range(0, 3) != 0, lim);
      end

      repeat (3) @(posedge i_clock);
      check("scoreboard drained", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
